// File: rtl/ucie_retry_replay_ctrl.sv
// ucie_retry_replay_ctrl: transmit-side link-level retry with sequence numbering and a circular replay buffer
module ucie_retry_replay_ctrl #(
    parameter int FLIT_W         = 256,
    parameter int DEPTH          = 16,
    parameter int SEQ_W          = 8,
    parameter int REPLAY_TIMEOUT = 1024,
    parameter int MAX_REPLAY     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [FLIT_W-1:0]          up_flit,
    input  logic                       up_valid,
    output logic                       up_ready,
    output logic [FLIT_W-1:0]          dn_flit,
    output logic [SEQ_W-1:0]           dn_seq,
    output logic                       dn_is_replay,
    output logic                       dn_valid,
    input  logic                       dn_ready,
    input  logic                       ack_valid,
    input  logic [SEQ_W-1:0]           ack_seq,
    input  logic                       nak_valid,
    input  logic [SEQ_W-1:0]           nak_seq,
    input  logic                       error_clear,
    output logic                       replay_active,
    output logic                       link_error,
    output logic [$clog2(DEPTH):0]     outstanding,
    output logic [15:0]                replay_total
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam int TW = $clog2(REPLAY_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_REPLAY + 1);
    localparam logic [1:0] S_NORMAL = 2'd0;
    localparam logic [1:0] S_REPLAY = 2'd1;
    localparam logic [1:0] S_ERROR  = 2'd2;

    logic [1:0]        state;
    logic [IW-1:0]     head, tail, rd;
    logic [SEQ_W-1:0]  next_seq, head_seq;
    logic [CW-1:0]     count;
    logic [TW-1:0]     timer;
    logic [RW-1:0]     consec;
    logic [15:0]       total;
    logic [FLIT_W-1:0] mem [DEPTH];

    logic              is_normal, is_replay, is_error, not_full, ready_i;
    logic              ack_ok, nak_ok, nak_rep, release_any, wr, hs, last, timeout, start, to_error;
    logic [SEQ_W-1:0]  ack_off, nak_off, count_s;
    logic [CW-1:0]     freed, count_n, roff_n;
    logic [IW-1:0]     head_n, roff;
    logic [RW-1:0]     consec_eff;

    // Window checks, release amount and replay-start decisions for this cycle
    always_comb begin
        is_normal   = state == S_NORMAL;
        is_replay   = state == S_REPLAY;
        is_error    = state == S_ERROR;
        not_full    = count < CW'(DEPTH);
        ready_i     = is_normal && dn_ready && not_full;
        count_s     = SEQ_W'(count);
        ack_off     = ack_seq - head_seq;
        nak_off     = nak_seq - head_seq;
        ack_ok      = ack_valid && !nak_valid && !is_error && ack_off < count_s;
        nak_ok      = nak_valid && !is_error && nak_off <= count_s;
        freed       = nak_ok ? CW'(nak_off) : ack_ok ? CW'(ack_off) + 1'b1 : '0;
        release_any = freed != '0;
        nak_rep     = nak_ok && nak_off != count_s;
        wr          = up_valid && ready_i;
        hs          = is_replay && dn_ready;
        last        = hs && rd == IW'(tail - 1'b1);
        timeout     = is_normal && count != '0 && !release_any && timer == TW'(REPLAY_TIMEOUT - 1);
        start       = nak_rep || timeout;
        consec_eff  = release_any ? '0 : consec;
        to_error    = start && consec_eff == RW'(MAX_REPLAY);
        head_n      = head + IW'(freed);
        count_n     = count + CW'(wr) - freed;
        roff        = rd - head;
        roff_n      = CW'(roff) + CW'(hs);
    end

    // Output mux between the live protocol-layer path and the replay buffer, forced to 0 in reset
    always_comb begin
        up_ready      = rst_n && ready_i;
        dn_valid      = rst_n && (is_replay || (is_normal && up_valid && not_full));
        dn_flit       = !rst_n ? '0 : is_replay ? mem[rd] : up_flit;
        dn_seq        = !rst_n ? '0 : is_replay ? head_seq + SEQ_W'(roff) : next_seq;
        dn_is_replay  = rst_n && is_replay;
        replay_active = rst_n && is_replay;
        link_error    = rst_n && is_error;
        outstanding   = rst_n ? count : '0;
        replay_total  = rst_n ? total : '0;
    end

    // Replay buffer storage, written on every accepted new flit
    always_ff @(posedge clk) begin
        if (wr) mem[tail] <= up_flit;
    end

    // Pointers, sequence numbers, timer and retry state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_NORMAL;
            head     <= '0;
            tail     <= '0;
            rd       <= '0;
            next_seq <= '0;
            head_seq <= '0;
            count    <= '0;
            timer    <= '0;
            consec   <= '0;
            total    <= '0;
        end else if (is_error) begin
            timer <= '0;
            if (error_clear) begin
                head     <= tail;
                head_seq <= next_seq;
                count    <= '0;
                consec   <= '0;
                state    <= S_NORMAL;
            end
        end else begin
            head     <= head_n;
            head_seq <= head_seq + SEQ_W'(freed);
            count    <= count_n;
            timer    <= (is_normal && !start && !release_any && count != '0) ? timer + 1'b1 : '0;
            if (wr) begin
                tail     <= tail + 1'b1;
                next_seq <= next_seq + 1'b1;
            end
            if (release_any) consec <= '0;
            if (start) begin
                if (to_error) state <= S_ERROR;
                else begin
                    consec <= consec_eff + 1'b1;
                    total  <= total == 16'hFFFF ? total : total + 1'b1;
                    rd     <= head_n;
                    state  <= S_REPLAY;
                end
            end else if (is_replay) begin
                if (count_n == '0 || last) state <= S_NORMAL;
                rd <= roff_n < freed ? head_n : rd + IW'(hs);
            end
        end
    end
endmodule
